pin_controller: RTL and testbench



---
 rtl/pin_controller.sv | 171 +++++++++++++++++
 tb/tb_pin_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pin_controller.sv
// Command-bus responder for a single FPGA pin: per-pin config registers, pin drive
// (low/high/hi-Z/square wave) and a saturating rising-edge counter on the pin input.
module pin_controller #(
    parameter logic [7:0]  POSITION    = 8'h00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] cmd_bus_addr,
    input  logic [31:0] cmd_bus_data,
    input  logic        cmd_bus_en,
    input  logic        cmd_bus_rd,
    input  logic        cmd_bus_wr,
    output logic [31:0] cmd_bus_rdata,
    output logic        cmd_bus_rvalid,
    input  logic        pin_in,
    output logic        pin_out,
    output logic        pin_oe
);

    typedef enum logic [2:0] {HIZ, LOW, HIGH, SQ_HI, SQ_LO} state_t;

    state_t                 state, state_next;
    logic [31:0]            cnt, cnt_next;
    logic [1:0]             mode;
    logic [31:0]            high_cycles, low_cycles, edge_count;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_prev;
    logic                   rise;
    logic                   sel, wr_en, rd_en;
    logic [7:0]             idx;
    logic [31:0]            hi_len, lo_len, hi_reload, lo_reload;
    logic [31:0]            read_value;
    logic                   out_next, oe_next;
    logic [2:0]             unused_addr;

    assign unused_addr = cmd_bus_addr[18:16];
    assign idx         = cmd_bus_addr[7:0];
    assign sel         = cmd_bus_en && (cmd_bus_addr[15:8] == POSITION);
    assign wr_en       = sel && cmd_bus_wr;
    assign rd_en       = sel && cmd_bus_rd && !cmd_bus_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff   <= '0;
            sync_prev <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1)
                sync_ff <= {sync_ff[SYNC_STAGES-2:0], pin_in};
            else
                sync_ff[0] <= pin_in;
            sync_prev <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign rise = sync_ff[SYNC_STAGES-1] & ~sync_prev;

    // A phase-length write landing on the reload edge must be used by that reload.
    assign hi_len    = (wr_en && idx == 8'h01) ? cmd_bus_data : high_cycles;
    assign lo_len    = (wr_en && idx == 8'h02) ? cmd_bus_data : low_cycles;
    assign hi_reload = (hi_len == '0) ? '0 : hi_len - 32'd1;
    assign lo_reload = (lo_len == '0) ? '0 : lo_len - 32'd1;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (wr_en && idx == 8'h00) begin
            case (cmd_bus_data[1:0])
                2'd0: state_next = LOW;
                2'd1: state_next = HIGH;
                2'd2: begin
                    state_next = SQ_HI;
                    cnt_next   = hi_reload;
                end
                default: state_next = HIZ;
            endcase
        end else begin
            case (state)
                SQ_HI: begin
                    if (cnt == '0) begin
                        state_next = SQ_LO;
                        cnt_next   = lo_reload;
                    end else begin
                        cnt_next = cnt - 32'd1;
                    end
                end
                SQ_LO: begin
                    if (cnt == '0) begin
                        state_next = SQ_HI;
                        cnt_next   = hi_reload;
                    end else begin
                        cnt_next = cnt - 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_next = 1'b0;
        oe_next  = 1'b1;
        case (state_next)
            HIGH, SQ_HI: out_next = 1'b1;
            LOW, SQ_LO:  out_next = 1'b0;
            default:     oe_next  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= HIZ;
            cnt     <= '0;
            pin_out <= 1'b0;
            pin_oe  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pin_out <= out_next;
            pin_oe  <= oe_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode        <= 2'd3;
            high_cycles <= 32'd1;
            low_cycles  <= 32'd1;
        end else if (wr_en) begin
            case (idx)
                8'h00:   mode        <= cmd_bus_data[1:0];
                8'h01:   high_cycles <= cmd_bus_data;
                8'h02:   low_cycles  <= cmd_bus_data;
                default: ;
            endcase
        end
    end

    // A clear coinciding with a detected edge wins; the edge is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            edge_count <= '0;
        else if (wr_en && idx == 8'h04)
            edge_count <= '0;
        else if (rise && edge_count != '1)
            edge_count <= edge_count + 32'd1;
    end

    always_comb begin
        read_value = '0;
        case (idx)
            8'h00:   read_value = {30'd0, mode};
            8'h01:   read_value = high_cycles;
            8'h02:   read_value = low_cycles;
            8'h04:   read_value = edge_count;
            default: read_value = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_bus_rdata  <= '0;
            cmd_bus_rvalid <= 1'b0;
        end else begin
            cmd_bus_rvalid <= rd_en;
            if (rd_en)
                cmd_bus_rdata <= read_value;
        end
    end

endmodule

// File: tb/tb_pin_controller.sv
// Scoreboard bench for pin_controller: a cycle-count reference model predicts pin
// levels, read data and edge counts; a negedge monitor compares the DUT against it.
module tb_pin_controller;

    localparam logic [7:0]  POS  = 8'h03;
    localparam int unsigned SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] addr = '0;
    logic [31:0] data = '0;
    logic        en = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        pin_in = 1'b0;
    logic        pin_out, pin_oe;

    int n_cmp = 0;
    int n_err = 0;

    pin_controller #(.POSITION(POS), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst),
        .cmd_bus_addr(addr), .cmd_bus_data(data), .cmd_bus_en(en),
        .cmd_bus_rd(rd), .cmd_bus_wr(wr),
        .cmd_bus_rdata(rdata), .cmd_bus_rvalid(rvalid),
        .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe)
    );

    always #5 clk = ~clk;

    // Reference model: phase boundaries tracked as absolute cycle numbers.
    int unsigned     m_mode  = 3;
    logic [31:0]     m_hi    = 32'd1;
    logic [31:0]     m_lo    = 32'd1;
    logic [31:0]     m_edges = '0;
    bit              m_level = 1'b0;
    longint          m_cyc   = 0;
    longint          m_end   = 0;
    bit              m_rvalid = 1'b0;
    logic [SYNC+1:0] hist = '0;
    logic [31:0]     exp_q[$];

    function automatic longint plen(input logic [31:0] v);
        return (v == 0) ? 64'd1 : longint'(v);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 3; m_hi = 32'd1; m_lo = 32'd1; m_edges = '0;
            m_level = 1'b0; m_rvalid = 1'b0; hist = '0;
            exp_q.delete();
        end else begin
            bit w, r, is_sel, rise, mode_wr;
            m_cyc++;
            hist   = {hist[SYNC:0], pin_in};
            rise   = hist[SYNC] && !hist[SYNC+1];
            is_sel = en && (addr[15:8] == POS);
            w      = is_sel && wr;
            r      = is_sel && rd && !wr;
            mode_wr = w && (addr[7:0] == 8'h00);
            m_rvalid = r;
            if (r) begin
                case (addr[7:0])
                    8'h00:   exp_q.push_back(32'(m_mode));
                    8'h01:   exp_q.push_back(m_hi);
                    8'h02:   exp_q.push_back(m_lo);
                    8'h04:   exp_q.push_back(m_edges);
                    default: exp_q.push_back(32'd0);
                endcase
            end
            if (w) begin
                case (addr[7:0])
                    8'h00: begin
                        m_mode = int'(data[1:0]);
                        if (m_mode == 2) begin
                            m_level = 1'b1;
                            m_end   = m_cyc + plen(m_hi);
                        end
                    end
                    8'h01: m_hi = data;
                    8'h02: m_lo = data;
                    default: ;
                endcase
            end
            if (!mode_wr && m_mode == 2 && m_cyc == m_end) begin
                m_level = !m_level;
                m_end   = m_cyc + plen(m_level ? m_hi : m_lo);
            end
            if (w && addr[7:0] == 8'h04)
                m_edges = '0;
            else if (rise && m_edges != 32'hFFFF_FFFF)
                m_edges = m_edges + 32'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            logic eo, ee;
            case (m_mode)
                0:       begin ee = 1'b1; eo = 1'b0;    end
                1:       begin ee = 1'b1; eo = 1'b1;    end
                2:       begin ee = 1'b1; eo = m_level; end
                default: begin ee = 1'b0; eo = 1'b0;    end
            endcase
            check("pin_oe", 32'(pin_oe), 32'(ee));
            check("pin_out", 32'(pin_out), 32'(eo));
            check("rvalid", 32'(rvalid), 32'(m_rvalid));
            if (rvalid) begin
                if (exp_q.size() == 0)
                    check("rdata_unexpected", rdata, 32'hDEAD_BEEF);
                else
                    check("rdata", rdata, exp_q.pop_front());
            end
        end
    end

    task automatic bus_op(input logic [15:0] a, input logic [31:0] d, input logic w, input logic r);
        addr = {3'($urandom_range(0, 7)), a};
        data = d; wr = w; rd = r; en = 1'b1;
        @(negedge clk);
        en = 1'b0; wr = 1'b0; rd = 1'b0; data = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rising_edges(input int n);
        repeat (n) begin
            pin_in = 1'b1; idle(3);
            pin_in = 1'b0; idle(3);
        end
    endtask

    initial begin
        logic [7:0] idx_tab [6];
        logic [7:0] slot, idx;
        idx_tab = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h07, 8'h10};

        idle(3);
        rst = 1'b0;
        idle(2);
        check("reset_oe", 32'(pin_oe), 32'd0);
        bus_op({POS, 8'h00}, '0, 1'b0, 1'b1);
        bus_op({POS, 8'h01}, '0, 1'b0, 1'b1);
        bus_op({POS, 8'h02}, '0, 1'b0, 1'b1);
        bus_op({POS, 8'h04}, '0, 1'b0, 1'b1);
        idle(2);

        bus_op({POS, 8'h01}, 32'd3, 1'b1, 1'b0);
        bus_op({POS, 8'h02}, 32'd5, 1'b1, 1'b0);
        bus_op({POS, 8'h00}, 32'd2, 1'b1, 1'b0);
        idle(17);
        bus_op({POS, 8'h02}, 32'd2, 1'b1, 1'b0);
        idle(6);
        bus_op({POS, 8'h01}, 32'd0, 1'b1, 1'b0);
        idle(12);
        bus_op({POS, 8'h00}, 32'd2, 1'b1, 1'b0);
        idle(2);
        bus_op({POS, 8'h00}, 32'd2, 1'b1, 1'b0);
        idle(6);

        bus_op({POS, 8'h04}, '0, 1'b1, 1'b0);
        rising_edges(7);
        bus_op({POS, 8'h04}, '0, 1'b0, 1'b1);

        // Clear lands on the edge where the synchronised rise is counted.
        pin_in = 1'b1;
        idle(2);
        bus_op({POS, 8'h04}, '0, 1'b1, 1'b0);
        pin_in = 1'b0;
        idle(3);
        bus_op({POS, 8'h04}, '0, 1'b0, 1'b1);

        idle(4);
        force dut.edge_count = 32'hFFFF_FFFD;
        m_edges = 32'hFFFF_FFFD;
        #1 release dut.edge_count;
        @(negedge clk);
        rising_edges(4);
        bus_op({POS, 8'h04}, '0, 1'b0, 1'b1);

        bus_op({8'h04, 8'h01}, 32'd99, 1'b1, 1'b0);
        bus_op(16'hFFFF, 32'd77, 1'b1, 1'b0);
        bus_op({POS, 8'h07}, 32'd55, 1'b1, 1'b0);
        bus_op({8'h04, 8'h00}, '0, 1'b0, 1'b1);
        bus_op({POS, 8'h07}, '0, 1'b0, 1'b1);
        bus_op({POS, 8'h01}, '0, 1'b0, 1'b1);
        bus_op({POS, 8'h04}, '0, 1'b0, 1'b1);

        bus_op({POS, 8'h01}, 32'd1, 1'b1, 1'b0);
        bus_op({POS, 8'h02}, 32'd8, 1'b1, 1'b0);
        bus_op({POS, 8'h00}, 32'd2, 1'b1, 1'b0);
        idle(3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_oe", 32'(pin_oe), 32'd0);
        check("async_rst_out", 32'(pin_out), 32'd0);
        check("async_rst_rvalid", 32'(rvalid), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(1);
        bus_op({POS, 8'h00}, '0, 1'b0, 1'b1);
        bus_op({POS, 8'h01}, 32'd4, 1'b1, 1'b1);
        idle(1);
        bus_op({POS, 8'h01}, '0, 1'b0, 1'b1);
        idle(2);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) pin_in = ~pin_in;
            if ($urandom_range(0, 9) < 4) begin
                slot = ($urandom_range(0, 3) != 0) ? POS : 8'($urandom_range(0, 255));
                idx  = idx_tab[$urandom_range(0, 5)];
                bus_op({slot, idx},
                       (idx == 8'h00) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 6)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                idle(1);
            end
        end

        idle(6);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
